// File: rtl/fb_write_arbiter_pkg.sv
// Shared frame-buffer write-path constants, arbitration modes and small helpers.
package fb_write_arbiter_pkg;

  localparam int unsigned FB_ADDR_WIDTH = 19;
  localparam int unsigned FB_DATA_WIDTH = 1;

  typedef enum int unsigned {
    ARB_FIXED = 0,
    ARB_RR    = 1
  } arb_mode_e;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Per-channel synchronous FIFO with async reset; exposes full/empty/count and the head entry.
module fb_write_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// N-channel frame-buffer write arbiter: per-channel FIFOs, fixed/round-robin grant, registered write port.
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = FB_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RR_MODE    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] in_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                         stall,
  output logic                         write_enable,
  output logic [ADDR_WIDTH-1:0]        write_addr,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic                         idle
);

  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BEAT_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [BEAT_W-1:0]   head  [CHANNELS];
  logic [CNT_W-1:0]    count [CHANNELS];
  logic [CH_W-1:0]     rr_ptr;
  logic                grant_vld;
  logic [CH_W-1:0]     grant_idx;
  logic                fire;

  assign in_ready = ~full & {CHANNELS{~rst}};
  assign push     = in_valid & in_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
    fb_write_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BEAT_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[c]),
      .push_data ({in_addr[c*ADDR_WIDTH +: ADDR_WIDTH], in_data[c*DATA_WIDTH +: DATA_WIDTH]}),
      .pop       (pop[c]),
      .head      (head[c]),
      .full      (full[c]),
      .empty     (empty[c]),
      .count     (count[c])
    );
  end

  // Rotate/priority-encode/un-rotate folded into one search starting at base, wrapping mod CHANNELS.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    base      = (RR_MODE == ARB_RR) ? 32'(rr_ptr) : 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = base + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
  end

  assign fire = grant_vld & ~stall;

  always_comb begin
    pop = '0;
    if (fire) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      rr_ptr       <= '0;
    end else begin
      write_enable <= fire;
      if (fire) {write_addr, write_data} <= head[grant_idx];
      else      {write_addr, write_data} <= '0;
      if (fire && RR_MODE == ARB_RR) rr_ptr <= CH_W'(wrap_inc(32'(grant_idx), CHANNELS));
    end
  end

  always_comb begin
    idle = ~write_enable;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (count[c] != '0) idle = 1'b0;
    end
  end

endmodule
